// File: rtl/store_align_buffer.sv
// Store align + AdES detect + FIFO drain onto the data bus, with load hazard.
// Define STORE_MERGE_EN to merge same-word stores into the tail entry.
module store_align_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_addr,
  input  logic [31:0]              in_data,
  input  logic [1:0]               in_msize,
  input  logic [1:0]               in_kind,
  output logic                     exc_ades,
  output logic [31:0]              exc_badvaddr,
  output logic                     dreq_valid,
  output logic [31:0]              dreq_addr,
  output logic [3:0]               dreq_strobe,
  output logic [31:0]              dreq_data,
  input  logic                     dresp_addr_ok,
  input  logic                     dresp_data_ok,
  input  logic [31:0]              ld_addr,
  input  logic [3:0]               ld_strobe,
  output logic                     ld_hazard,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} st_t;

  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  strb;
    logic [31:0] data;
  } entry_t;

  st_t         state, state_nx;
  entry_t      mem [DEPTH];
  logic [PW-1:0] head, tail, off;
  logic [CW-1:0] cnt;

  logic [1:0]  k;
  logic [4:0]  sh, swl_m;
  logic [3:0]  a_strb;
  logic [31:0] a_data;
  logic        a_mis, normal;
  logic        merge_hit, accept, enq, pop;
  logic        unused;

  assign unused = ^ld_addr[1:0];

  always_comb begin
    k      = in_addr[1:0];
    sh     = {k, 3'b000};
    swl_m  = (5'd2 << k) - 5'd1;
    normal = (in_kind != 2'd1) && (in_kind != 2'd2);
    a_strb = '0;
    a_data = '0;
    a_mis  = 1'b0;
    unique case (1'b1)
      (in_kind == 2'd1): begin
        a_strb = swl_m[3:0];
        a_data = in_data >> {~k, 3'b000};
      end
      (in_kind == 2'd2): begin
        a_strb = 4'b1111 << k;
        a_data = in_data << sh;
      end
      (normal && in_msize == 2'd0): begin
        a_strb = 4'b0001 << k;
        a_data = {24'h0, in_data[7:0]} << sh;
      end
      (normal && in_msize == 2'd1): begin
        a_strb = 4'b0011 << k;
        a_data = {16'h0, in_data[15:0]} << sh;
        a_mis  = k[0];
      end
      default: begin
        a_strb = 4'b1111;
        a_data = in_data;
        a_mis  = |k;
      end
    endcase
  end

`ifdef STORE_MERGE_EN
  logic [PW-1:0] last;
  logic [31:0]   bmask;
  entry_t        merged;

  assign last = tail - 1'b1;

  // the issuing head must not change under the bus
  assign merge_hit = !a_mis && (cnt != '0)
                  && (mem[last].waddr == in_addr[31:2])
                  && !((state != IDLE) && (cnt == CW'(1)));

  always_comb begin
    bmask = {{8{a_strb[3]}}, {8{a_strb[2]}},
             {8{a_strb[1]}}, {8{a_strb[0]}}};
    merged       = mem[last];
    merged.strb  = mem[last].strb | a_strb;
    merged.data  = (mem[last].data & ~bmask) | (a_data & bmask);
  end
`else
  assign merge_hit = 1'b0;
`endif

  assign in_ready = resetn && ((cnt < CW'(DEPTH)) || merge_hit);
  assign accept   = in_valid && in_ready;
  assign enq      = accept && !a_mis && !merge_hit;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    dreq_valid = 1'b0;
    pop        = 1'b0;
    unique case (state)
      IDLE: if (cnt != '0) state_nx = ADDR;
      ADDR: begin
        dreq_valid = 1'b1;
        if (dresp_addr_ok) begin
          if (dresp_data_ok) begin
            pop      = 1'b1;
            state_nx = (cnt > CW'(1)) ? ADDR : IDLE;
          end else begin
            state_nx = DATA;
          end
        end
      end
      DATA: if (dresp_data_ok) begin
        pop      = 1'b1;
        state_nx = (cnt > CW'(1)) ? ADDR : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head         <= '0;
      tail         <= '0;
      cnt          <= '0;
      exc_ades     <= 1'b0;
      exc_badvaddr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      exc_ades <= accept && a_mis;
      if (accept && a_mis) exc_badvaddr <= in_addr;
      if (enq) begin
        mem[tail] <= '{in_addr[31:2], a_strb, a_data};
        tail      <= tail + 1'b1;
      end
`ifdef STORE_MERGE_EN
      if (accept && merge_hit) mem[last] <= merged;
`endif
      if (pop) head <= head + 1'b1;
      cnt <= cnt + CW'(enq) - CW'(pop);
    end
  end

  assign dreq_addr   = dreq_valid ? {mem[head].waddr, 2'b00} : '0;
  assign dreq_strobe = dreq_valid ? mem[head].strb : '0;
  assign dreq_data   = dreq_valid ? mem[head].data : '0;

  always_comb begin
    ld_hazard = 1'b0;
    off       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head;
      if (({1'b0, off} < cnt)
          && (mem[i].waddr == ld_addr[31:2])
          && |(mem[i].strb & ld_strobe))
        ld_hazard = 1'b1;
    end
  end

  assign count = cnt;
  assign empty = (cnt == '0);

endmodule

// File: tb/tb_store_align_buffer.sv
// Bench for store_align_buffer: directed steps then random traffic vs a
// byte-lane queue model.
module tb_store_align_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, in_ready;
  logic [31:0] in_addr, in_data;
  logic [1:0]  in_msize, in_kind;
  logic        exc_ades;
  logic [31:0] exc_badvaddr;
  logic        dreq_valid;
  logic [31:0] dreq_addr, dreq_data;
  logic [3:0]  dreq_strobe;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [31:0] ld_addr;
  logic [3:0]  ld_strobe;
  logic        ld_hazard;
  logic [$clog2(DEPTH):0] count;
  logic        empty;

  always #5 clk = ~clk;

  store_align_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data),
    .in_msize(in_msize), .in_kind(in_kind),
    .exc_ades(exc_ades), .exc_badvaddr(exc_badvaddr),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
    .ld_addr(ld_addr), .ld_strobe(ld_strobe), .ld_hazard(ld_hazard),
    .count(count), .empty(empty)
  );

  typedef struct {
    logic [29:0] wa;
    logic [3:0]  st;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%08h exp=%08h", tag, obs, exp);
    end
  endtask

  // lane-by-lane placement of source bytes
  function automatic void model(input logic [31:0] a, input logic [31:0] d,
                                input logic [1:0] ms, input logic [1:0] kd,
                                output logic [3:0] st,
                                output logic [31:0] wd, output bit mis);
    int k;
    int src;
    k = int'(a[1:0]);
    st = '0; wd = '0; mis = 1'b0;
    for (int i = 0; i < 4; i++) begin
      src = -1;
      if (kd == 2'd1) begin
        if (i <= k) src = 3 - k + i;
      end else if (kd == 2'd2) begin
        if (i >= k) src = i - k;
      end else if (ms == 2'd0) begin
        if (i == k) src = 0;
      end else if (ms == 2'd1) begin
        if (i == k || i == k + 1) src = i - k;
      end else begin
        src = i;
      end
      if (src >= 0) begin
        st[i] = 1'b1;
        wd[8*i +: 8] = d[8*src +: 8];
      end
    end
    if (kd != 2'd1 && kd != 2'd2)
      mis = (ms == 2'd1) ? (k % 2 != 0) : (ms == 2'd2 && k != 0);
  endfunction

  function automatic bit merge_ok(input logic [31:0] a);
`ifdef STORE_MERGE_EN
    return q.size() >= 2 && q[q.size()-1].wa == a[31:2];
`else
    return 1'b0;
`endif
  endfunction

  task automatic put(input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] ms, input logic [1:0] kd);
    logic [3:0]  st;
    logic [31:0] wd;
    bit mis, mg, rdy;
    ent_t e;
    model(a, d, ms, kd, st, wd, mis);
    mg  = !mis && merge_ok(a);
    rdy = (q.size() < DEPTH) || mg;
    in_addr = a; in_data = d; in_msize = ms; in_kind = kd;
    in_valid = 1'b1;
    #1;
    chk("in_ready", in_ready, rdy);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (rdy && !mis) begin
      if (mg) begin
        e = q[q.size()-1];
        for (int i = 0; i < 4; i++)
          if (st[i]) e.d[8*i +: 8] = wd[8*i +: 8];
        e.st = e.st | st;
        q[q.size()-1] = e;
      end else begin
        e.wa = a[31:2]; e.st = st; e.d = wd;
        q.push_back(e);
      end
    end
    chk("count", count, q.size());
    chk("empty", empty, q.size() == 0);
    chk("exc_ades", exc_ades, rdy && mis);
    if (rdy && mis) chk("exc_badvaddr", exc_badvaddr, a);
    @(posedge clk); #1;
    chk("exc_pulse_end", exc_ades, 1'b0);
  endtask

  task automatic chk_head();
    chk("dreq_addr", dreq_addr, {q[0].wa, 2'b00});
    chk("dreq_strobe", dreq_strobe, q[0].st);
    chk("dreq_data", dreq_data, q[0].d);
  endtask

  task automatic drain_one(input bit same);
    int n;
    n = 0;
    while (dreq_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("dreq_valid", dreq_valid, 1'b1);
    if (dreq_valid !== 1'b1 || q.size() == 0) return;
    repeat ($urandom_range(0, 2)) begin
      chk_head();
      @(posedge clk); #1;
    end
    chk_head();
    if (same) begin
      dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
      @(posedge clk); #1;
      dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    end else begin
      dresp_addr_ok = 1'b1;
      @(posedge clk); #1;
      dresp_addr_ok = 1'b0;
      chk("data_phase_valid", dreq_valid, 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      dresp_data_ok = 1'b1;
      @(posedge clk); #1;
      dresp_data_ok = 1'b0;
    end
    void'(q.pop_front());
    chk("pop_count", count, q.size());
    chk("pop_empty", empty, q.size() == 0);
    chk("next_valid", dreq_valid, q.size() != 0);
  endtask

  task automatic haz(input logic [31:0] a, input logic [3:0] s);
    bit exp;
    ld_addr = a; ld_strobe = s;
    #1;
    exp = 1'b0;
    foreach (q[i])
      if (q[i].wa == a[31:2] && (q[i].st & s) != 4'b0) exp = 1'b1;
    chk("ld_hazard", ld_hazard, exp);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  kd, ms;
    int r, guard;
    resetn = 1'b0; in_valid = 1'b0;
    in_addr = '0; in_data = '0; in_msize = '0; in_kind = '0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    ld_addr = '0; ld_strobe = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_dreq_valid", dreq_valid, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_exc", exc_ades, 1'b0);
    chk("rst_badvaddr", exc_badvaddr, 0);
    chk("rst_dreq_addr", dreq_addr, 0);
    chk("rst_dreq_strobe", dreq_strobe, 0);
    chk("rst_dreq_data", dreq_data, 0);
    chk("rst_hazard", ld_hazard, 1'b0);
    resetn = 1'b1;
    #1;
    chk("post_rst_ready", in_ready, 1'b1);

    put(32'h0000_1003, 32'h1234_5678, 2'd0, 2'd0);
    drain_one(1'b1);

    put(32'h0000_2001, 32'hAABB_CCDD, 2'd2, 2'd1);
    put(32'h0000_2001, 32'hAABB_CCDD, 2'd2, 2'd2);
    drain_one(1'b0);
    drain_one(1'b1);

    put(32'h0000_3001, 32'h0000_BEEF, 2'd1, 2'd0);

    for (int i = 0; i < DEPTH; i++)
      put(32'h0000_0100 + 32'(4 * i), $urandom, 2'd2, 2'd0);
    put(32'h0000_0100 + 32'(4 * DEPTH), 32'h5555_5555, 2'd2, 2'd0);
    // a pop in this cycle must not open a slot for this cycle
    chk_head();
    in_addr = 32'h0000_0200; in_data = 32'h6666_6666;
    in_msize = 2'd2; in_kind = 2'd0; in_valid = 1'b1;
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
    #1;
    chk("full_pop_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    void'(q.pop_front());
    chk("full_pop_count", count, q.size());
    chk("ready_after_pop", in_ready, 1'b1);
    chk("b2b_valid", dreq_valid, 1'b1);
    while (q.size() > 0) drain_one(1'b1);

    put(32'h0000_4000, 32'hCAFE_F00D, 2'd2, 2'd0);
    haz(32'h0000_4002, 4'b1100);
    haz(32'h0000_4004, 4'b1111);
    drain_one(1'b0);
    haz(32'h0000_4002, 4'b1100);

`ifdef STORE_MERGE_EN
    put(32'h0000_6000, 32'h0BAD_0BAD, 2'd2, 2'd0);
    put(32'h0000_5000, 32'h0000_0011, 2'd0, 2'd0);
    put(32'h0000_5001, 32'h0000_0022, 2'd0, 2'd0);
    chk("merge_count", count, 2);
    drain_one(1'b1);
    drain_one(1'b0);
`endif

    put(32'h0000_7000, 32'h1111_1111, 2'd2, 2'd0);
    put(32'h0000_7004, 32'h2222_2222, 2'd2, 2'd0);
    dresp_addr_ok = 1'b1;
    @(posedge clk); #1;
    dresp_addr_ok = 1'b0;
    resetn = 1'b0;
    #1;
    q.delete();
    chk("midrst_count", count, 0);
    chk("midrst_valid", dreq_valid, 1'b0);
    chk("midrst_ready", in_ready, 1'b0);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("midrst_idle", dreq_valid, 1'b0);
    chk("midrst_empty", empty, 1'b1);
    haz(32'h0000_7000, 4'b1111);

    for (int it = 0; it < 200; it++) begin
      r = $urandom_range(0, 9);
      if (r < 5) begin
        a = 32'h0000_5000 | (32'($urandom_range(0, 3)) << 2)
                          | 32'($urandom_range(0, 3));
        kd = 2'($urandom_range(0, 2));
        ms = (kd != 2'd0) ? 2'd2 : 2'($urandom_range(0, 2));
        put(a, $urandom, ms, kd);
      end else if (r < 8 && q.size() > 0) begin
        drain_one(1'($urandom_range(0, 1)));
      end else begin
        haz(32'h0000_5000 | (32'($urandom_range(0, 3)) << 2),
            4'($urandom_range(1, 15)));
      end
    end
    guard = 0;
    while (q.size() > 0 && guard < 2 * DEPTH) begin
      drain_one(1'b1);
      guard++;
    end
    chk("final_empty", empty, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
